// File: rtl/coriolis_kernel_vec_top.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : coriolis_kernel_vec_top                                      |
// | Description : Vectorised Coriolis rotation kernel, un=(A*u+B*v)>>>FRACW,    |
// |               vn=(A*v-B*u)>>>FRACW per lane, with credit-based input flow   |
// |               control and an output FIFO. Optional macro CORIOLIS_SAT_EN    |
// |               selects clamping plus a sticky sat_flag output.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module coriolis_kernel_vec_top #(
    parameter int DATAW      = 32,
    parameter int FRACW      = 16,
    parameter int NLANES     = 4,
    parameter int PIPE_LAT   = 3,
    parameter int FIFO_DEPTH = 8,
    parameter int CNTW       = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [CNTW-1:0]          n_items,
    input  logic [DATAW-1:0]         coef_a,
    input  logic [DATAW-1:0]         coef_b,
    output logic                     busy,
    output logic                     done,
    input  logic [NLANES*DATAW-1:0]  u,
    input  logic [NLANES*DATAW-1:0]  v,
    input  logic                     ivalid_u,
    input  logic                     ivalid_v,
    output logic                     iready,
    output logic [NLANES*DATAW-1:0]  un,
    output logic [NLANES*DATAW-1:0]  vn,
    output logic                     ovalid,
    input  logic                     oready_un,
    input  logic                     oready_vn
`ifdef CORIOLIS_SAT_EN
    ,
    output logic                     sat_flag
`endif
);

    localparam int c_STREAMW = NLANES * DATAW;
    localparam int c_PST     = PIPE_LAT - 1;
    localparam int c_AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CW      = $clog2(FIFO_DEPTH + PIPE_LAT + 2) + 1;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    logic [1:0]              r_state;
    logic [CNTW-1:0]         r_n_items;
    logic [CNTW-1:0]         r_acc_cnt;
    logic [CNTW-1:0]         r_emit_cnt;
    logic [DATAW-1:0]        r_coef_a;
    logic [DATAW-1:0]        r_coef_b;
    logic                    r_zero_done;

    // r_vld[0] is the input register, r_vld[PIPE_LAT] the result register
    logic [PIPE_LAT:0]       r_vld;
    logic [c_STREAMW-1:0]    r_in_u;
    logic [c_STREAMW-1:0]    r_in_v;
    logic signed [2*DATAW-1:0] r_pau [c_PST][NLANES];
    logic signed [2*DATAW-1:0] r_pbv [c_PST][NLANES];
    logic signed [2*DATAW-1:0] r_pav [c_PST][NLANES];
    logic signed [2*DATAW-1:0] r_pbu [c_PST][NLANES];
    logic [c_STREAMW-1:0]    r_res_un;
    logic [c_STREAMW-1:0]    r_res_vn;
    logic [c_STREAMW-1:0]    w_res_un;
    logic [c_STREAMW-1:0]    w_res_vn;

    logic [2*c_STREAMW-1:0]  r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]         r_wr_ptr;
    logic [c_AW-1:0]         r_rd_ptr;
    logic [c_CW-1:0]         r_count;

    logic [c_CW-1:0]         w_inflight;
    logic                    w_iready;
    logic                    w_in_fire;
    logic                    w_ovalid;
    logic                    w_out_fire;
    logic                    w_push;
    logic [CNTW-1:0]         w_acc_next;
    logic [CNTW-1:0]         w_emit_next;

    function automatic logic signed [2*DATAW-1:0] f_sext(input logic [DATAW-1:0] x);
        return {{DATAW{x[DATAW-1]}}, x};
    endfunction

    // Credit: every accepted item already owns a FIFO slot, so the datapath never stalls
    always_comb begin
        w_inflight = '0;
        for (int s = 0; s <= PIPE_LAT; s++) begin
            w_inflight = w_inflight + c_CW'(r_vld[s]);
        end
    end

    assign w_iready    = (r_state == c_RUN) && ((r_count + w_inflight) < c_CW'(FIFO_DEPTH));
    assign w_in_fire   = w_iready & ivalid_u & ivalid_v;
    assign w_ovalid    = (r_count != '0);
    assign w_out_fire  = w_ovalid & oready_un & oready_vn;
    assign w_push      = r_vld[PIPE_LAT];
    assign w_acc_next  = r_acc_cnt + CNTW'(1);
    assign w_emit_next = r_emit_cnt + CNTW'(1);

    // Job controller
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_n_items   <= '0;
            r_acc_cnt   <= '0;
            r_emit_cnt  <= '0;
            r_coef_a    <= '0;
            r_coef_b    <= '0;
            r_zero_done <= 1'b0;
        end else begin
            r_zero_done <= 1'b0;
            if (w_in_fire)  r_acc_cnt  <= w_acc_next;
            if (w_out_fire) r_emit_cnt <= w_emit_next;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        if (n_items != '0) begin
                            r_n_items  <= n_items;
                            r_coef_a   <= coef_a;
                            r_coef_b   <= coef_b;
                            r_acc_cnt  <= '0;
                            r_emit_cnt <= '0;
                            r_state    <= c_RUN;
                        end else begin
                            r_zero_done <= 1'b1;
                        end
                    end
                end
                c_RUN: begin
                    if (w_in_fire && (w_acc_next == r_n_items)) r_state <= c_DRAIN;
                end
                c_DRAIN: begin
                    if (w_out_fire && (w_emit_next == r_n_items)) r_state <= c_DONE;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_vld <= '0;
        else     r_vld <= {r_vld[PIPE_LAT-1:0], w_in_fire};
    end

    // Datapath registers carry no reset; validity is tracked solely by r_vld
    always_ff @(posedge clk) begin
        r_in_u <= u;
        r_in_v <= v;
        for (int l = 0; l < NLANES; l++) begin
            r_pau[0][l] <= f_sext(r_in_u[l*DATAW +: DATAW]) * f_sext(r_coef_a);
            r_pbv[0][l] <= f_sext(r_in_v[l*DATAW +: DATAW]) * f_sext(r_coef_b);
            r_pav[0][l] <= f_sext(r_in_v[l*DATAW +: DATAW]) * f_sext(r_coef_a);
            r_pbu[0][l] <= f_sext(r_in_u[l*DATAW +: DATAW]) * f_sext(r_coef_b);
            for (int s = 1; s < c_PST; s++) begin
                r_pau[s][l] <= r_pau[s-1][l];
                r_pbv[s][l] <= r_pbv[s-1][l];
                r_pav[s][l] <= r_pav[s-1][l];
                r_pbu[s][l] <= r_pbu[s-1][l];
            end
        end
        r_res_un <= w_res_un;
        r_res_vn <= w_res_vn;
    end

`ifdef CORIOLIS_SAT_EN
    localparam logic [DATAW-1:0] c_MAX = {1'b0, {(DATAW-1){1'b1}}};
    localparam logic [DATAW-1:0] c_MIN = {1'b1, {(DATAW-1){1'b0}}};
    logic [NLANES-1:0] w_clamp;
    logic              r_sat_flag;
`endif

    for (genvar l = 0; l < NLANES; l++) begin : g_lane
        logic signed [2*DATAW:0] w_sum_un;
        logic signed [2*DATAW:0] w_sum_vn;
        logic signed [2*DATAW:0] w_sh_un;
        logic signed [2*DATAW:0] w_sh_vn;

        assign w_sum_un = {r_pau[c_PST-1][l][2*DATAW-1], r_pau[c_PST-1][l]}
                        + {r_pbv[c_PST-1][l][2*DATAW-1], r_pbv[c_PST-1][l]};
        assign w_sum_vn = {r_pav[c_PST-1][l][2*DATAW-1], r_pav[c_PST-1][l]}
                        - {r_pbu[c_PST-1][l][2*DATAW-1], r_pbu[c_PST-1][l]};
        assign w_sh_un  = w_sum_un >>> FRACW;
        assign w_sh_vn  = w_sum_vn >>> FRACW;

`ifdef CORIOLIS_SAT_EN
        logic [DATAW:0] w_hi_un;
        logic [DATAW:0] w_hi_vn;
        logic           w_ovf_un;
        logic           w_ovf_vn;

        // Fits in DATAW bits only if everything above bit DATAW-2 is sign extension
        assign w_hi_un  = w_sh_un[2*DATAW:DATAW-1];
        assign w_hi_vn  = w_sh_vn[2*DATAW:DATAW-1];
        assign w_ovf_un = !((&w_hi_un) | (~|w_hi_un));
        assign w_ovf_vn = !((&w_hi_vn) | (~|w_hi_vn));
        assign w_res_un[l*DATAW +: DATAW] = w_ovf_un ? (w_sh_un[2*DATAW] ? c_MIN : c_MAX)
                                                     : w_sh_un[DATAW-1:0];
        assign w_res_vn[l*DATAW +: DATAW] = w_ovf_vn ? (w_sh_vn[2*DATAW] ? c_MIN : c_MAX)
                                                     : w_sh_vn[DATAW-1:0];
        assign w_clamp[l] = w_ovf_un | w_ovf_vn;
`else
        logic w_unused_hi;
        assign w_res_un[l*DATAW +: DATAW] = w_sh_un[DATAW-1:0];
        assign w_res_vn[l*DATAW +: DATAW] = w_sh_vn[DATAW-1:0];
        assign w_unused_hi = ^{w_sh_un[2*DATAW:DATAW], w_sh_vn[2*DATAW:DATAW]};
`endif
    end

`ifdef CORIOLIS_SAT_EN
    always_ff @(posedge clk) begin
        if (rst)                                    r_sat_flag <= 1'b0;
        else if ((r_state == c_IDLE) && start)      r_sat_flag <= 1'b0;
        else if (r_vld[PIPE_LAT-1] && (|w_clamp))   r_sat_flag <= 1'b1;
    end
    assign sat_flag = r_sat_flag;
`endif

    // Output FIFO
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {r_res_un, r_res_vn};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)     r_wr_ptr <= r_wr_ptr + c_AW'(1);
            if (w_out_fire) r_rd_ptr <= r_rd_ptr + c_AW'(1);
            case ({w_push, w_out_fire})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign un     = w_ovalid ? r_mem[r_rd_ptr][2*c_STREAMW-1:c_STREAMW] : '0;
    assign vn     = w_ovalid ? r_mem[r_rd_ptr][c_STREAMW-1:0]           : '0;
    assign ovalid = w_ovalid;
    assign iready = w_iready;
    assign busy   = (r_state == c_RUN) || (r_state == c_DRAIN);
    assign done   = (r_state == c_DONE) || r_zero_done;

endmodule
`default_nettype wire

// File: tb/tb_coriolis_kernel_vec_top.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_coriolis_kernel_vec_top                                   |
// | Description : Directed self-checking bench for coriolis_kernel_vec_top.    |
// |               Honours CORIOLIS_SAT_EN for the saturation case.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_coriolis_kernel_vec_top;

    localparam int c_DATAW      = 32;
    localparam int c_NLANES     = 4;
    localparam int c_SW         = c_NLANES * c_DATAW;
    localparam int c_PIPE_LAT   = 3;
    localparam int c_FIFO_DEPTH = 8;
    localparam logic [31:0] c_ONE = 32'h0001_0000;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [31:0]     n_items;
    logic [31:0]     coef_a;
    logic [31:0]     coef_b;
    logic            busy;
    logic            done;
    logic [c_SW-1:0] u;
    logic [c_SW-1:0] v;
    logic            ivalid_u;
    logic            ivalid_v;
    logic            iready;
    logic [c_SW-1:0] un;
    logic [c_SW-1:0] vn;
    logic            ovalid;
    logic            oready_un;
    logic            oready_vn;
`ifdef CORIOLIS_SAT_EN
    logic            sat_flag;
`endif

    coriolis_kernel_vec_top dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .n_items   (n_items),
        .coef_a    (coef_a),
        .coef_b    (coef_b),
        .busy      (busy),
        .done      (done),
        .u         (u),
        .v         (v),
        .ivalid_u  (ivalid_u),
        .ivalid_v  (ivalid_v),
        .iready    (iready),
        .un        (un),
        .vn        (vn),
        .ovalid    (ovalid),
        .oready_un (oready_un),
        .oready_vn (oready_vn)
`ifdef CORIOLIS_SAT_EN
        ,
        .sat_flag  (sat_flag)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int done_total = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (done === 1'b1) done_total <= done_total + 1;

    int n_cmp = 0;
    int n_err = 0;
    int n_acc;
    int t_first_acc;
    int t_first_ov;
    int done_base;
    logic [c_SW-1:0] q_u[$];
    logic [c_SW-1:0] q_v[$];
    logic [c_SW-1:0] q_eun[$];
    logic [c_SW-1:0] q_evn[$];

    task automatic check_value(input string tag, input logic [c_SW-1:0] obs, input logic [c_SW-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [c_SW-1:0] rep(input logic [31:0] x);
        return {c_NLANES{x}};
    endfunction

    task automatic clear_q();
        q_u.delete(); q_v.delete(); q_eun.delete(); q_evn.delete();
    endtask

    task automatic push_item(input logic [c_SW-1:0] iu, iv, eu, ev);
        q_u.push_back(iu); q_v.push_back(iv); q_eun.push_back(eu); q_evn.push_back(ev);
    endtask

    // Identity items: lane i of item j carries base+j*16+i on both streams
    task automatic fill_identity(input int n, input int ubase, input int vbase);
        logic [c_SW-1:0] tu, tv;
        clear_q();
        for (int j = 0; j < n; j++) begin
            for (int i = 0; i < c_NLANES; i++) begin
                tu[i*32 +: 32] = 32'(ubase + j*16 + i);
                tv[i*32 +: 32] = 32'(vbase + j*16 + i);
            end
            push_item(tu, tv, tu, tv);
        end
    endtask

    task automatic start_job(input int n, input logic [31:0] a, input logic [31:0] b);
        done_base   = done_total;
        n_acc       = 0;
        t_first_acc = 0;
        t_first_ov  = -1;
        start = 1'b1; n_items = 32'(n); coef_a = a; coef_b = b;
        @(posedge clk); #1;
        start = 1'b0; n_items = 32'd0;
        coef_a = 32'hDEAD_BEEF; coef_b = 32'h1234_5678;
    endtask

    task automatic drive_items(input int n);
        int  w;
        bit  rdy;
        for (int j = 0; j < n; j++) begin
            u = q_u[j]; v = q_v[j]; ivalid_u = 1'b1; ivalid_v = 1'b1;
            w = 0; rdy = 1'b0;
            while (!rdy && w < 400) begin
                @(negedge clk); rdy = iready;
                @(posedge clk); #1;
                w++;
            end
            if (!rdy) begin
                check_value("drive_timeout", 0, 1);
                break;
            end
            if (n_acc == 0) t_first_acc = cyc;
            n_acc++;
        end
        ivalid_u = 1'b0; ivalid_v = 1'b0;
    endtask

    task automatic collect(input int n, input int hold);
        int k = 0;
        int w = 0;
        oready_un = (hold == 0);
        oready_vn = 1'b1;
        while (k < n && w < 1000) begin
            @(negedge clk); w++;
            if (w == hold) begin
                check_value("acc_when_blocked", 128'(n_acc), 128'(c_FIFO_DEPTH));
                check_value("iready_when_blocked", 128'(iready), 0);
                oready_un = 1'b1;
            end
            if (ovalid && t_first_ov < 0) t_first_ov = cyc;
            if (ovalid && oready_un && oready_vn) begin
                check_value($sformatf("un[%0d]", k), un, q_eun[k]);
                check_value($sformatf("vn[%0d]", k), vn, q_evn[k]);
                k++;
            end
        end
        if (k < n) check_value("collect_timeout", 128'(k), 128'(n));
    endtask

    task automatic run_job(input string tag, input int n, input logic [31:0] a, input logic [31:0] b,
                           input int hold);
        start_job(n, a, b);
        check_value({tag, "_busy"}, 128'(busy), 1);
        fork
            drive_items(n);
            collect(n, hold);
        join
        repeat (3) @(posedge clk);
        #1;
        check_value({tag, "_done_once"}, 128'(done_total - done_base), 1);
        check_value({tag, "_idle"}, 128'(busy), 0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; n_items = '0; coef_a = '0; coef_b = '0;
        u = '0; v = '0; ivalid_u = 1'b0; ivalid_v = 1'b0; oready_un = 1'b1; oready_vn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_value("rst_busy",   128'(busy),   0);
        check_value("rst_done",   128'(done),   0);
        check_value("rst_iready", 128'(iready), 0);
        check_value("rst_ovalid", 128'(ovalid), 0);
        check_value("rst_un", un, 0);
        check_value("rst_vn", vn, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Identity with lane-distinct data, plus first-output latency
        fill_identity(16, 0, 100);
        run_job("ident", 16, c_ONE, 32'd0, 0);
        check_value("ident_latency", 128'(t_first_ov - t_first_acc), 128'(c_PIPE_LAT + 1));

        // Swap: A=0, B=1.0 -> un=v, vn=-u
        clear_q();
        push_item(rep(32'd5), rep(32'd7), rep(32'd7), rep(32'hFFFF_FFFB));
        run_job("swap", 1, 32'd0, c_ONE, 0);

        // A=1.5, B=0.5: (10,-4)->(13,-11); (-3,3)->(-3,6)
        clear_q();
        push_item(rep(32'd10), rep(32'hFFFF_FFFC), rep(32'd13), rep(32'hFFFF_FFF5));
        push_item(rep(32'hFFFF_FFFD), rep(32'd3), rep(32'hFFFF_FFFD), rep(32'd6));
        run_job("mixed", 2, 32'h0001_8000, 32'h0000_8000, 0);

        // A=0.5, B=0: -1.5 floors to -2, 1.5 floors to 1
        clear_q();
        push_item(rep(32'hFFFF_FFFD), rep(32'd3), rep(32'hFFFF_FFFE), rep(32'd1));
        run_job("floor", 1, 32'h0000_8000, 32'd0, 0);

        // Zero-length job
        done_base = done_total;
        start = 1'b1; n_items = 32'd0; coef_a = c_ONE; coef_b = 32'd0;
        @(posedge clk); #1;
        start = 1'b0;
        check_value("zero_done",   128'(done),   1);
        check_value("zero_busy",   128'(busy),   0);
        check_value("zero_iready", 128'(iready), 0);
        @(posedge clk); #1;
        check_value("zero_done_low", 128'(done),  0);
        check_value("zero_busy_low", 128'(busy),  0);

        // Backpressure: un consumer stalls for 20 cycles
        fill_identity(32, 1000, 5000);
        run_job("bp", 32, c_ONE, 32'd0, 20);

        // Large coefficients: clamps with the macro, wraps without
        clear_q();
`ifdef CORIOLIS_SAT_EN
        push_item(rep(32'h7FFF_FFFF), rep(32'h7FFF_FFFF), rep(32'h7FFF_FFFF), rep(32'd0));
`else
        push_item(rep(32'h7FFF_FFFF), rep(32'h7FFF_FFFF), rep(32'hFFFF_0002), rep(32'd0));
`endif
        run_job("big", 1, 32'h7FFF_0000, 32'h7FFF_0000, 0);
`ifdef CORIOLIS_SAT_EN
        check_value("sat_flag_set", 128'(sat_flag), 1);
`endif

        // Reset after 5 of 16 items accepted
        fill_identity(16, 0, 100);
        start_job(16, c_ONE, 32'd0);
        oready_un = 1'b0; oready_vn = 1'b0;
        drive_items(5);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_value("rstjob_ovalid", 128'(ovalid), 0);
        check_value("rstjob_busy",   128'(busy),   0);
        check_value("rstjob_iready", 128'(iready), 0);
`ifdef CORIOLIS_SAT_EN
        check_value("rstjob_sat_flag", 128'(sat_flag), 0);
`endif
        repeat (3) @(posedge clk);
        #1;
        check_value("rstjob_no_done", 128'(done_total - done_base), 0);

        clear_q();
        for (int j = 0; j < 4; j++) begin
            push_item(rep(32'(j + 1)), rep(32'(j + 20)), rep(32'(j + 20)), rep(-32'(j + 1)));
        end
        run_job("after_rst", 4, 32'd0, c_ONE, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
